// File: rtl/program_loader.sv
// Instruction-word loader: packs fields into 25-bit words, stores 256 of them, 1-cycle registered readback.
// Optional LOADER_WRAP_EN: pointer wraps at 255 with a sticky Wrapped flag instead of stopping in FULL.
module program_loader (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Start,
    input  logic        In_valid,
    output logic        In_ready,
    input  logic [4:0]  Opcode,
    input  logic [3:0]  Destin,
    input  logic [3:0]  Source1,
    input  logic [3:0]  Source2,
    input  logic [8:0]  Imm,
    input  logic        ImmMode,
    input  logic [7:0]  Rd_addr,
    output logic [24:0] Rd_data,
    output logic [8:0]  Count,
    output logic        Full
`ifdef LOADER_WRAP_EN
    ,
    output logic        Wrapped
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL} state_t;

    state_t       r_state;
    state_t       w_next;
    logic [7:0]   r_wr_ptr;
    logic [8:0]   r_count;
    logic [24:0]  r_rd_data;
    logic [24:0]  w_word;
    logic         w_xfer;
    logic [24:0]  w_mem [256];

    assign w_word = ImmMode ? {Opcode, Destin, Source1, 3'b000, Imm}
                            : {Opcode, Destin, Source1, Source2, 8'h00};

    // Start takes priority over a coincident transfer, which is dropped.
    assign w_xfer = In_valid && (r_state == S_LOAD) && !Start;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        In_ready = (r_state == S_LOAD);
`ifdef LOADER_WRAP_EN
        Full     = 1'b0;
`else
        Full     = (r_state == S_FULL);
`endif
        if (Start) begin
            w_next = S_LOAD;
        end
`ifndef LOADER_WRAP_EN
        else if (w_xfer && (r_wr_ptr == 8'hFF)) begin
            w_next = S_FULL;
        end
`endif
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_mem[Rd_addr];
            if (Start) begin
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else if (w_xfer) begin
                r_wr_ptr <= r_wr_ptr + 8'd1;
                if (r_count != 9'd256) begin
                    r_count <= r_count + 9'd1;
                end
            end
        end
    end

`ifdef LOADER_WRAP_EN
    logic r_wrapped;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_wrapped <= 1'b0;
        end else if (Start) begin
            r_wrapped <= 1'b0;
        end else if (w_xfer && (r_wr_ptr == 8'hFF)) begin
            r_wrapped <= 1'b1;
        end
    end

    assign Wrapped = r_wrapped;
`endif

    // Storage is flops so reset can clear every word at once.
    for (genvar gi = 0; gi < 256; gi++) begin : g_mem
        logic [24:0] r_word;

        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                r_word <= '0;
            end else if (w_xfer && (r_wr_ptr == 8'(gi))) begin
                r_word <= w_word;
            end
        end

        assign w_mem[gi] = r_word;
    end

    assign Rd_data = r_rd_data;
    assign Count   = r_count;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: vector table plus sequences for full/wrap, start-during-transfer and reset abort.
module tb_program_loader;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Start;
    logic        In_valid;
    logic        In_ready;
    logic [4:0]  Opcode;
    logic [3:0]  Destin;
    logic [3:0]  Source1;
    logic [3:0]  Source2;
    logic [8:0]  Imm;
    logic        ImmMode;
    logic [7:0]  Rd_addr;
    logic [24:0] Rd_data;
    logic [8:0]  Count;
    logic        Full;
`ifdef LOADER_WRAP_EN
    logic        Wrapped;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    program_loader dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .In_valid(In_valid), .In_ready(In_ready),
        .Opcode(Opcode), .Destin(Destin), .Source1(Source1), .Source2(Source2), .Imm(Imm),
        .ImmMode(ImmMode), .Rd_addr(Rd_addr), .Rd_data(Rd_data), .Count(Count), .Full(Full)
`ifdef LOADER_WRAP_EN
        ,
        .Wrapped(Wrapped)
`endif
    );

    typedef struct {
        logic        start;
        logic        valid;
        logic [4:0]  op;
        logic [3:0]  d;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic [8:0]  imm;
        logic        mode;
        logic [7:0]  rd;
        logic [24:0] e_rd;
        logic [8:0]  e_cnt;
        logic        e_rdy;
        logic        e_full;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [24:0] enc(input logic [4:0] op, input logic [3:0] d, input logic [3:0] s1,
                                        input logic [3:0] s2, input logic [8:0] imm, input logic mode);
        return mode ? {op, d, s1, 3'b000, imm} : {op, d, s1, s2, 8'h00};
    endfunction

    task automatic drive(input logic st, input logic v, input logic [4:0] op, input logic [3:0] d,
                         input logic [3:0] s1, input logic [3:0] s2, input logic [8:0] imm,
                         input logic mode, input logic [7:0] rd);
        Start = st; In_valid = v; Opcode = op; Destin = d; Source1 = s1;
        Source2 = s2; Imm = imm; ImmMode = mode; Rd_addr = rd;
    endtask

    // Pattern word i: fields derived from the index so every address holds a distinct value.
    task automatic drive_pat(input int i, input logic st, input logic [7:0] rd);
        logic [7:0] b;
        b = 8'(i);
        drive(st, 1'b1, b[4:0], b[7:4], b[3:0], ~b[3:0], {1'b1, b}, b[0], rd);
    endtask

    function automatic logic [24:0] pat(input int i);
        logic [7:0] b;
        b = 8'(i);
        return enc(b[4:0], b[7:4], b[3:0], ~b[3:0], {1'b1, b}, b[0]);
    endfunction

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        drive(1'b0, 1'b0, '0, '0, '0, '0, '0, 1'b0, 8'd0);
        step();
        Rst_n = 1'b1;
        step();
    endtask

    initial begin
        //         st  v   op     d     s1    s2    imm     md  rd     e_rd          cnt  rdy  full
        tbl[0]  = '{0, 1, 5'h03, 4'h2, 4'h1, 4'h4, 9'h000, 0, 8'd0, 25'h0000000, 9'd0, 0, 0};
        tbl[1]  = '{1, 1, 5'h03, 4'h2, 4'h1, 4'h4, 9'h000, 0, 8'd0, 25'h0000000, 9'd0, 1, 0};
        tbl[2]  = '{0, 1, 5'h03, 4'h2, 4'h1, 4'h4, 9'h000, 0, 8'd0, 25'h0000000, 9'd1, 1, 0};
        tbl[3]  = '{0, 0, 5'h00, 4'h0, 4'h0, 4'h0, 9'h000, 0, 8'd0, 25'h0321400, 9'd1, 1, 0};
        tbl[4]  = '{0, 1, 5'h1F, 4'hF, 4'h0, 4'hA, 9'h1AB, 1, 8'd0, 25'h0321400, 9'd2, 1, 0};
        tbl[5]  = '{0, 0, 5'h00, 4'h0, 4'h0, 4'h0, 9'h000, 0, 8'd1, 25'h1FF01AB, 9'd2, 1, 0};
        tbl[6]  = '{0, 1, 5'h0A, 4'h5, 4'h6, 4'h7, 9'h1FF, 0, 8'd2, 25'h0000000, 9'd3, 1, 0};
        tbl[7]  = '{0, 0, 5'h00, 4'h0, 4'h0, 4'h0, 9'h000, 0, 8'd2, 25'h0A56700, 9'd3, 1, 0};
        tbl[8]  = '{0, 0, 5'h00, 4'h0, 4'h0, 4'h0, 9'h000, 0, 8'd3, 25'h0000000, 9'd3, 1, 0};
        tbl[9]  = '{1, 0, 5'h00, 4'h0, 4'h0, 4'h0, 9'h000, 0, 8'd1, 25'h1FF01AB, 9'd0, 1, 0};
        tbl[10] = '{0, 0, 5'h00, 4'h0, 4'h0, 4'h0, 9'h000, 0, 8'd0, 25'h0321400, 9'd0, 1, 0};

        Rst_n = 1'b0;
        drive(1'b0, 1'b0, '0, '0, '0, '0, '0, 1'b0, 8'd0);
        #12;
        check("reset_count", 32'(Count), 32'd0);
        check("reset_ready", 32'(In_ready), 32'd0);
        check("reset_full", 32'(Full), 32'd0);
        check("reset_rd_data", 32'(Rd_data), 32'd0);
`ifdef LOADER_WRAP_EN
        check("reset_wrapped", 32'(Wrapped), 32'd0);
`endif
        @(negedge Clk);
        Rst_n = 1'b1;
        step();

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].start, tbl[i].valid, tbl[i].op, tbl[i].d, tbl[i].s1, tbl[i].s2,
                  tbl[i].imm, tbl[i].mode, tbl[i].rd);
            step();
            check($sformatf("vec%0d_rd_data", i), 32'(Rd_data), 32'(tbl[i].e_rd));
            check($sformatf("vec%0d_count", i), 32'(Count), 32'(tbl[i].e_cnt));
            check($sformatf("vec%0d_ready", i), 32'(In_ready), 32'(tbl[i].e_rdy));
            check($sformatf("vec%0d_full", i), 32'(Full), 32'(tbl[i].e_full));
        end

        // Start coincident with a transfer at pointer 5
        do_reset();
        drive(1'b1, 1'b0, '0, '0, '0, '0, '0, 1'b0, 8'd0);
        step();
        for (int i = 0; i < 5; i++) begin
            drive_pat(i, 1'b0, 8'd0);
            step();
        end
        check("pre_start_count", 32'(Count), 32'd5);
        drive_pat(100, 1'b1, 8'd5);
        step();
        check("start_win_count", 32'(Count), 32'd0);
        drive_pat(200, 1'b0, 8'd5);
        step();
        check("start_win_no_write5", 32'(Rd_data), 32'd0);
        check("start_win_count1", 32'(Count), 32'd1);
        drive(1'b0, 1'b0, '0, '0, '0, '0, '0, 1'b0, 8'd0);
        step();
        check("start_win_addr0", 32'(Rd_data), 32'(pat(200)));

        // Fill all 256 words
        do_reset();
        drive(1'b1, 1'b0, '0, '0, '0, '0, '0, 1'b0, 8'd0);
        step();
        for (int i = 0; i < 256; i++) begin
            drive_pat(i, 1'b0, 8'd0);
            step();
        end
        check("fill_count", 32'(Count), 32'd256);
`ifdef LOADER_WRAP_EN
        check("fill_full", 32'(Full), 32'd0);
        check("fill_ready", 32'(In_ready), 32'd1);
        check("fill_wrapped", 32'(Wrapped), 32'd1);
`else
        check("fill_full", 32'(Full), 32'd1);
        check("fill_ready", 32'(In_ready), 32'd0);
`endif
        drive_pat(77, 1'b0, 8'd0);
        step();
        check("extra_rd_old0", 32'(Rd_data), 32'(pat(0)));
        check("extra_count", 32'(Count), 32'd256);
        drive(1'b0, 1'b0, '0, '0, '0, '0, '0, 1'b0, 8'd0);
        step();
`ifdef LOADER_WRAP_EN
        check("extra_mem0", 32'(Rd_data), 32'(pat(77)));
`else
        check("extra_mem0", 32'(Rd_data), 32'(pat(0)));
`endif
        Rd_addr = 8'd255;
        step();
        check("fill_mem255", 32'(Rd_data), 32'(pat(255)));
        Start = 1'b1;
        step();
        Start = 1'b0;
        check("restart_count", 32'(Count), 32'd0);
        check("restart_full", 32'(Full), 32'd0);
        check("restart_ready", 32'(In_ready), 32'd1);
`ifdef LOADER_WRAP_EN
        check("restart_wrapped", 32'(Wrapped), 32'd0);
`endif

        // Reset mid-load after 10 writes
        do_reset();
        drive(1'b1, 1'b0, '0, '0, '0, '0, '0, 1'b0, 8'd0);
        step();
        for (int i = 0; i < 10; i++) begin
            drive_pat(i + 1, 1'b0, 8'd3);
            step();
        end
        check("midload_count", 32'(Count), 32'd10);
        check("midload_rd3", 32'(Rd_data), 32'(pat(4)));
        #2 Rst_n = 1'b0;
        #1;
        check("abort_count", 32'(Count), 32'd0);
        check("abort_ready", 32'(In_ready), 32'd0);
        check("abort_rd_data", 32'(Rd_data), 32'd0);
        check("abort_full", 32'(Full), 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        drive_pat(9, 1'b0, 8'd0);
        step();
        step();
        check("post_reset_idle_ready", 32'(In_ready), 32'd0);
        check("post_reset_idle_count", 32'(Count), 32'd0);
        In_valid = 1'b0;
        for (int a = 0; a < 256; a++) begin
            Rd_addr = 8'(a);
            step();
            check($sformatf("cleared_addr%0d", a), 32'(Rd_data), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
